multicycle_main_fsm: RTL and testbench



---
 rtl/multicycle_main_fsm.sv | 151 +++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle ARM datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional FSM_ILLEGAL_TRAP_EN: Op=11 traps forever and sets a sticky Illegal flag.
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               InstrDone,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 'd0,
        DECODE   = 'd1,
        MEMADR   = 'd2,
        MEMREAD  = 'd3,
        MEMWB    = 'd4,
        MEMWRITE = 'd5,
        EXECUTER = 'd6,
        EXECUTEI = 'd7,
        ALUWB    = 'd8,
        BRANCH   = 'd9,
        TRAP     = 'd10
    } state_t;

    state_t state, next_state;

    // Funct[4:1] only matter to the ALU decoder, not to sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    assign State = state;

    always_comb begin
        next_state = state;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        InstrDone  = 1'b0;
        case (state)
            FETCH: begin
                // Reset gating keeps the PC/IR untouched while reset is held.
                IRWrite   = MemReady & ~reset;
                NextPC    = MemReady & ~reset;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: begin
`ifdef FSM_ILLEGAL_TRAP_EN
                        next_state = TRAP;
`else
                        next_state = FETCH;
                        InstrDone  = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next_state = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = MemReady;
                if (MemReady) next_state = FETCH;
            end
            EXECUTER: begin
                ALUOp      = 1'b1;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegW       = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                Branch     = 1'b1;
                InstrDone  = 1'b1;
                next_state = FETCH;
            end
`ifdef FSM_ILLEGAL_TRAP_EN
            TRAP:    next_state = TRAP;
`endif
            default: next_state = FETCH;
        endcase
    end

`ifdef FSM_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      illegal_q <= 1'b0;
        else if (next_state == TRAP && state != TRAP)   illegal_q <= 1'b1;
    end
    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: stimulus pushes expected per-cycle outputs, monitor compares.
module tb_multicycle_main_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       MemReady = 1'b0;
    logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, InstrDone, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .InstrDone(InstrDone), .Illegal(Illegal),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw, npc, adr;
        logic [1:0] sa, sb, rs;
        logic       aop, rw, mw, br, done;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
        logic       ill;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    ctrl_t act;
    assign act = '{IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, InstrDone};

    // Spec control table, indexed by the hand-written expected state of each cycle.
    function automatic ctrl_t exp_ctrl(input logic [3:0] s, input logic mr, input logic [1:0] op, input logic rst);
        ctrl_t c = '0;
        case (s)
            4'd0: begin c.irw = mr & ~rst; c.npc = mr & ~rst; c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10; end
            4'd1: begin
                c.sa = 2'b01; c.sb = 2'b10; c.rs = 2'b10;
`ifndef FSM_ILLEGAL_TRAP_EN
                c.done = (op == 2'b11);
`endif
            end
            4'd2: c.sb = 2'b01;
            4'd3: c.adr = 1'b1;
            4'd4: begin c.rs = 2'b01; c.rw = 1'b1; c.done = 1'b1; end
            4'd5: begin c.adr = 1'b1; c.mw = 1'b1; c.done = mr; end
            4'd6: c.aop = 1'b1;
            4'd7: begin c.sb = 2'b01; c.aop = 1'b1; end
            4'd8: begin c.rw = 1'b1; c.done = 1'b1; end
            4'd9: begin c.sb = 2'b01; c.rs = 2'b10; c.br = 1'b1; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Drive one cycle's inputs, queue what the DUT must show this cycle, then advance.
    task automatic cyc(input logic [1:0] op, input logic [5:0] f, input logic mr, input logic rst,
                       input logic [3:0] st, input logic ill);
        Op = op; Funct = f; MemReady = mr; reset = rst;
        q.push_back('{st, exp_ctrl(st, mr, op, rst), ill});
        @(posedge clk); #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (State !== e.st) begin
                    n_fail++;
                    $display("FAIL state @%0t: got %0d expected %0d", $time, State, e.st);
                end
                n_checks++;
                if (act !== e.c) begin
                    n_fail++;
                    $display("FAIL ctrl @%0t (state %0d): got %b expected %b", $time, e.st, act, e.c);
                end
                n_checks++;
                if (Illegal !== e.ill) begin
                    n_fail++;
                    $display("FAIL illegal @%0t: got %b expected %b", $time, Illegal, e.ill);
                end
            end
        end
    end

    initial begin : stim
        @(posedge clk); #2;
        // Reset held: FETCH row with IRWrite/NextPC suppressed even though MemReady=1.
        cyc(2'b00, 6'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        // ADD reg; garbage Op/Funct outside DECODE/MEMADR must be ignored.
        cyc(2'b00, 6'b001000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b00, 6'b001000, 1'b1, 1'b0, 4'd1, 1'b0);
        cyc(2'b11, 6'b111111, 1'b1, 1'b0, 4'd6, 1'b0);
        cyc(2'b01, 6'b100001, 1'b1, 1'b0, 4'd8, 1'b0);
        // ADD immediate
        cyc(2'b00, 6'b101000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b00, 6'b101000, 1'b1, 1'b0, 4'd1, 1'b0);
        cyc(2'b10, 6'b000000, 1'b1, 1'b0, 4'd7, 1'b0);
        cyc(2'b10, 6'b000000, 1'b1, 1'b0, 4'd8, 1'b0);
        // LDR with two wait cycles in MEMREAD
        cyc(2'b01, 6'b000001, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 6'b000001, 1'b1, 1'b0, 4'd1, 1'b0);
        cyc(2'b01, 6'b000001, 1'b1, 1'b0, 4'd2, 1'b0);
        cyc(2'b11, 6'b000000, 1'b0, 1'b0, 4'd3, 1'b0);
        cyc(2'b11, 6'b000000, 1'b0, 1'b0, 4'd3, 1'b0);
        cyc(2'b11, 6'b000000, 1'b1, 1'b0, 4'd3, 1'b0);
        cyc(2'b11, 6'b000000, 1'b1, 1'b0, 4'd4, 1'b0);
        // STR with one wait cycle in MEMWRITE
        cyc(2'b01, 6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b01, 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
        cyc(2'b01, 6'b000000, 1'b1, 1'b0, 4'd2, 1'b0);
        cyc(2'b01, 6'b000001, 1'b0, 1'b0, 4'd5, 1'b0);
        cyc(2'b01, 6'b000001, 1'b1, 1'b0, 4'd5, 1'b0);
        // FETCH stall for three cycles, then branch
        cyc(2'b10, 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b10, 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b10, 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(2'b10, 6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b10, 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
        // BRANCH cycle checked at negedge, then reset asserted before the next edge
        Op = 2'b00; MemReady = 1'b1;
        q.push_back('{4'd9, exp_ctrl(4'd9, 1'b1, 2'b00, 1'b0), 1'b0});
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        q.push_back('{4'd0, exp_ctrl(4'd0, 1'b1, 2'b00, 1'b1), 1'b0});
        -> sample_ev;
        @(posedge clk); #2;
        cyc(2'b00, 6'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        // Op=11 decode
        cyc(2'b11, 6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b11, 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
`ifdef FSM_ILLEGAL_TRAP_EN
        cyc(2'b00, 6'b000000, 1'b1, 1'b0, 4'd10, 1'b1);
        cyc(2'b01, 6'b000001, 1'b1, 1'b0, 4'd10, 1'b1);
        cyc(2'b10, 6'b000000, 1'b1, 1'b0, 4'd10, 1'b1);
        cyc(2'b00, 6'b000000, 1'b1, 1'b1, 4'd0, 1'b0);
        cyc(2'b00, 6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
`else
        cyc(2'b00, 6'b000000, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(2'b00, 6'b000000, 1'b1, 1'b0, 4'd1, 1'b0);
        cyc(2'b00, 6'b000000, 1'b1, 1'b0, 4'd6, 1'b0);
`endif
        @(negedge clk); #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
